stickit_key_scanner: RTL and testbench
======================================

Name: stickit_key_scanner

Overview:
- Input-direction counterpart to the StickIt! charlieplexed LED digit driver.
- Scans the same 8 tristate lines as a charlieplexed key matrix: drives one line low, senses the other 7 through pull-ups.
- Debounces each of the 56 key sites and reports the stable key map.
- Emits press/release events over a valid/ready stream for the host logic.

Parameters:
- SETTLE_CYCLES, 215, clk_i cycles a line is driven before sampling; covers pin settling and the synchroniser.
- DEBOUNCE_SCANS, 4, consecutive full scans with a differing raw value needed to flip a key's stable state; legal range 1..15.

Ports:
- clk_i  in  1  system clock (12 MHz nominal)
- rst_n_i  in  1  synchronous reset, active-low
- enable_i  in  1  1 = scan; 0 = release all lines and idle
- lines_i  in  8  raw pin sense values, asynchronous
- tris_o  out  8  per-line tristate control; 1 = hi-Z, 0 = driven
- drive_o  out  8  per-line output value when driven; always 0
- keys_o  out  56  debounced key state; 1 = pressed
- scan_done_o  out  1  one-cycle pulse after line 7 is sampled
- event_valid_o  out  1  event available
- event_ready_i  in  1  consumer accepts the event
- event_key_o  out  6  key index 0..55
- event_press_o  out  1  1 = press, 0 = release

Behaviour:
- Reset (rst_n_i=0 at a clk_i edge):
  - tris_o=8'hFF, drive_o=0, keys_o=0, event_valid_o=0, event_key_o=0, event_press_o=0, scan_done_o=0.
  - All debounce counters and pending bits cleared; line index k=0; state IDLE.
  - A reset mid-scan aborts immediately; no event is emitted.
- Synchroniser: lines_i passes through a 2-flop synchroniser (sync_r).
- Key index mapping:
  - Driven line k; sense lines j≠k in ascending order get position p=0..6.
  - key = 7*k + p. Example: k=2, j=5 gives p=4, key=18.
  - Pressed when the sync_r bit for line j is 0 while line k is driven.
- FSM:
  - IDLE: tris_o=FF. If enable_i=1, go to DRIVE with k=0 and timer=SETTLE_CYCLES-1.
  - DRIVE: tris_o[k]=0, all other bits 1. Timer decrements each cycle; at 0, go to SAMPLE.
  - SAMPLE (1 cycle, tris_o unchanged):
    - Compute 7 raw bits and update their 7 debounce counters.
    - k=(k+1) mod 8. When k wraps 7→0, assert scan_done_o for this cycle.
    - Go to DRIVE with the timer reloaded.
  - Line period = SETTLE_CYCLES+1 cycles; scan period = 8*(SETTLE_CYCLES+1) = 1728 cycles at default.
  - enable_i=0 in any state: IDLE next cycle; tris_o=FF that cycle; k=0; keys_o, counters and pending bits retained; no partial-scan update.
- Debounce, per key, on its SAMPLE cycle only:
  - raw==stable: counter cleared.
  - raw!=stable: counter incremented. If the new value equals DEBOUNCE_SCANS, stable toggles, counter clears, and the key's pending bit is set.
  - keys_o reflects the new stable value the cycle after SAMPLE.
- Event stream:
  - Output register loads when empty, or when valid&&ready in the same cycle.
  - Load source: lowest-index set pending bit. event_key_o = that index; event_press_o = that key's current stable value. The pending bit is cleared on load.
  - While event_valid_o=1 and event_ready_i=0, key and press stay stable.
  - Back-to-back events at 1 per cycle are allowed.
  - A pending-bit set and clear in the same cycle: set wins.
  - Multiple toggles while pending coalesce; the reported polarity is the stable value at load time.
  - No events are lost except by this coalescing.
- Width rules:
  - Timer width is $clog2(SETTLE_CYCLES).
  - Counter width is 4 bits.
  - The key index multiply is by constant 7 (shift-subtract); no DSP.

Decomposition:
- Package stickit_keys_pkg:
  - constants N_LINES=8, N_KEYS=56, KEY_W=6;
  - scan state enum {IDLE, DRIVE, SAMPLE};
  - function key_index(k, j) returning 7*k + (j>k ? j-1 : j).
- Sub-module stickit_key_debounce: one key's counter, stable bit and toggle-pulse output; instantiated 56× under a generate with a per-key sample-enable.
- Priority encoder and event register stay in the top level.

Test Plan:
- Reset/idle: assert rst_n_i=0 for 3 cycles with enable_i=0 → tris_o=FF, keys_o=0, event_valid_o=0. Raise enable_i → tris_o=8'hFE from the next cycle for 215 cycles; scan_done_o pulses every 1728 cycles.
- Press: hold line 5 low whenever line 2 is driven, for 4 scans → keys_o[18]=1 after the 4th SAMPLE of k=2; one event (key=18, press=1). Release for 4 scans → event (18, 0).
- Glitch: the same press held for only 3 scans, then released → keys_o[18] stays 0 and no event.
- Backpressure: ready=0 while keys 3 and 40 debounce to pressed together → valid with key=3 held stable for 100 cycles. Raise ready → key=40 on the next cycle, then valid=0.
- Mid-scan disable/reset: drop enable_i during DRIVE of k=4 → tris_o=FF next cycle and keys_o retained; re-enable restarts at k=0. Assert rst_n_i=0 mid-DRIVE → all outputs return to reset values and no event.
- Coalesce: key 10 presses, and releases after 4 more scans, while ready=0 and another event blocks the register → a single event (10, 0) after accept.

Source files
------------

// File: rtl/stickit_key_scanner_pkg.sv
// Shared constants, scan state encoding and key-site numbering for the key scanner.
// Latency: none (declarations only).
// Backpressure: not applicable.
package stickit_keys_pkg;

  localparam int N_LINES = 8;
  localparam int N_KEYS  = 56;
  localparam int KEY_W   = 6;

  typedef enum logic [1:0] {
    IDLE,
    DRIVE,
    SAMPLE
  } scan_state_t;

  // Key number for driven line k sensed on line j (j != k): 7*k plus the
  // rank of j among the seven undriven lines. 7*k is formed as 8*k - k.
  function automatic logic [KEY_W-1:0] key_index(input logic [2:0] k, input logic [2:0] j);
    logic [KEY_W-1:0] base;
    logic [KEY_W-1:0] pos;
    base = ({3'b000, k} << 3) - {3'b000, k};
    pos  = (j > k) ? ({3'b000, j} - 6'd1) : {3'b000, j};
    return base + pos;
  endfunction

endpackage

// File: rtl/stickit_key_debounce.sv
// One key site: counts consecutive disagreeing scans and flips the stable state.
// Latency: stable updates the cycle after a qualifying sample; toggle is combinational in that sample cycle.
// Backpressure: none; evaluates only when sample is high.
module stickit_key_debounce #(
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sample,
  input  logic raw,
  output logic stable,
  output logic toggle
);

  localparam logic [3:0] LIMIT = 4'(DEBOUNCE_SCANS);

  logic [3:0] cnt_r;
  logic [3:0] cnt_inc;

  assign cnt_inc = cnt_r + 4'd1;
  assign toggle  = sample && (raw != stable) && (cnt_inc == LIMIT);

  // Agreement resets the run; the LIMIT-th consecutive disagreement flips the key.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_r  <= 4'd0;
      stable <= 1'b0;
    end else if (sample) begin
      if (raw == stable) begin
        cnt_r <= 4'd0;
      end else if (toggle) begin
        stable <= ~stable;
        cnt_r  <= 4'd0;
      end else begin
        cnt_r <= cnt_inc;
      end
    end
  end

endmodule

// File: rtl/stickit_key_scanner.sv
// Charlieplexed 8-line key scanner: debounced 56-key map plus press/release event stream.
// Latency: one line every SETTLE_CYCLES+1 cycles; keys_o the cycle after a line sample; event two cycles after a toggle.
// Backpressure: held event stays stable while ready is low; new toggles wait in per-key pending bits.
module stickit_key_scanner
  import stickit_keys_pkg::*;
#(
  parameter int SETTLE_CYCLES  = 215,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 enable_i,
  input  logic [N_LINES-1:0]   lines_i,
  output logic [N_LINES-1:0]   tris_o,
  output logic [N_LINES-1:0]   drive_o,
  output logic [N_KEYS-1:0]    keys_o,
  output logic                 scan_done_o,
  output logic                 event_valid_o,
  input  logic                 event_ready_i,
  output logic [KEY_W-1:0]     event_key_o,
  output logic                 event_press_o
);

  localparam int                  TIMER_W    = $clog2(SETTLE_CYCLES);
  localparam logic [TIMER_W-1:0]  TIMER_LOAD = TIMER_W'(SETTLE_CYCLES - 1);
  localparam logic [N_KEYS-1:0]   KEY_ONE    = N_KEYS'(1);

  scan_state_t          state_r, state_n;
  logic [2:0]           k_r, k_n;
  logic [TIMER_W-1:0]   timer_r, timer_n;
  logic                 sample_en;
  logic [N_LINES-1:0]   sync_q, sync_r;

  logic [N_KEYS-1:0]    sel_vec, raw_vec, stable_vec, toggle_vec;
  logic [N_KEYS-1:0]    pending_r, clear_mask;
  logic                 pe_found;
  logic [KEY_W-1:0]     pe_idx;
  logic                 ev_load;

  // Two-flop synchroniser for the asynchronous pin senses; idle pins read high.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      sync_q <= '1;
      sync_r <= '1;
    end else begin
      sync_q <= lines_i;
      sync_r <= sync_q;
    end
  end

  // Scan state, driven line index and settle timer.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_r <= IDLE;
      k_r     <= 3'd0;
      timer_r <= '0;
    end else begin
      state_r <= state_n;
      k_r     <= k_n;
      timer_r <= timer_n;
    end
  end

  // Next-state logic; dropping enable abandons the scan without sampling.
  always_comb begin
    state_n   = state_r;
    k_n       = k_r;
    timer_n   = timer_r;
    sample_en = 1'b0;
    if (!enable_i) begin
      state_n = IDLE;
      k_n     = 3'd0;
    end else begin
      case (state_r)
        IDLE: begin
          state_n = DRIVE;
          k_n     = 3'd0;
          timer_n = TIMER_LOAD;
        end
        DRIVE: begin
          if (timer_r == '0) state_n = SAMPLE;
          else               timer_n = timer_r - 1'b1;
        end
        SAMPLE: begin
          sample_en = 1'b1;
          k_n       = k_r + 3'd1;
          timer_n   = TIMER_LOAD;
          state_n   = DRIVE;
        end
        default: state_n = IDLE;
      endcase
    end
  end

  assign tris_o      = (state_r == IDLE) ? '1 : ~(N_LINES'(1) << k_r);
  assign drive_o     = '0;
  assign scan_done_o = sample_en && (k_r == 3'd7);

  // One debouncer per key site, enabled only while its drive line is sampled.
  for (genvar gk = 0; gk < N_LINES; gk++) begin : g_drive
    for (genvar gj = 0; gj < N_LINES; gj++) begin : g_sense
      if (gj != gk) begin : g_key
        localparam int IDX = int'(key_index(3'(gk), 3'(gj)));
        assign sel_vec[IDX] = sample_en && (k_r == 3'(gk));
        assign raw_vec[IDX] = ~sync_r[gj];
        stickit_key_debounce #(
          .DEBOUNCE_SCANS(DEBOUNCE_SCANS)
        ) u_debounce (
          .clk    (clk_i),
          .rst_n  (rst_n_i),
          .sample (sel_vec[IDX]),
          .raw    (raw_vec[IDX]),
          .stable (stable_vec[IDX]),
          .toggle (toggle_vec[IDX])
        );
      end
    end
  end

  assign keys_o = stable_vec;

  // Lowest-numbered pending key wins the event register.
  always_comb begin
    pe_found = 1'b0;
    pe_idx   = '0;
    for (int i = N_KEYS - 1; i >= 0; i--) begin
      if (pending_r[i]) begin
        pe_found = 1'b1;
        pe_idx   = KEY_W'(i);
      end
    end
  end

  assign ev_load    = !event_valid_o || event_ready_i;
  assign clear_mask = (ev_load && pe_found) ? (KEY_ONE << pe_idx) : '0;

  // Pending bits (a fresh toggle beats a same-cycle clear) and the event output register.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      pending_r     <= '0;
      event_valid_o <= 1'b0;
      event_key_o   <= '0;
      event_press_o <= 1'b0;
    end else begin
      pending_r <= (pending_r & ~clear_mask) | toggle_vec;
      if (ev_load) begin
        if (pe_found) begin
          event_valid_o <= 1'b1;
          event_key_o   <= pe_idx;
          event_press_o <= stable_vec[pe_idx];
        end else begin
          event_valid_o <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_stickit_key_scanner.sv
// Directed self-checking bench for stickit_key_scanner with a charlieplexed key-matrix pin model.
// Latency: scan-level stimulus; checks sampled on the falling clock edge.
// Backpressure: drives event_ready_i low/high to exercise holding and coalescing.
module tb_stickit_key_scanner;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic [7:0]  lines;
  logic [7:0]  tris;
  logic [7:0]  drive;
  logic [55:0] keys;
  logic        scan_done;
  logic        ev_valid;
  logic        ev_ready;
  logic [5:0]  ev_key;
  logic        ev_press;

  always #5 clk = ~clk;

  stickit_key_scanner dut (
    .clk_i         (clk),
    .rst_n_i       (rst_n),
    .enable_i      (enable),
    .lines_i       (lines),
    .tris_o        (tris),
    .drive_o       (drive),
    .keys_o        (keys),
    .scan_done_o   (scan_done),
    .event_valid_o (ev_valid),
    .event_ready_i (ev_ready),
    .event_key_o   (ev_key),
    .event_press_o (ev_press)
  );

  // Closed contact between drive line k and sense line j is bit 8*k+j.
  logic [63:0] pairs;

  always_comb begin
    lines = 8'hFF;
    for (int k = 0; k < 8; k++) begin
      if (!tris[k]) begin
        lines[k] = drive[k];
        for (int j = 0; j < 8; j++) begin
          if (pairs[8*k+j]) lines[j] = 1'b0;
        end
      end
    end
  end

  typedef struct packed {
    logic [5:0] key;
    logic       press;
  } ev_t;

  ev_t evq[$];

  always @(posedge clk) begin
    if (ev_valid && ev_ready) evq.push_back('{key: ev_key, press: ev_press});
  end

  typedef struct {
    int k;
    int j;
    int key;
  } vec_t;

  vec_t tbl[6];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Returns at the falling edge of each scan_done pulse.
  task automatic wait_scans(input int n);
    for (int s = 0; s < n; s++) begin
      bit got = 1'b0;
      for (int c = 0; c < 2000; c++) begin
        @(negedge clk);
        if (scan_done) begin
          got = 1'b1;
          break;
        end
      end
      if (!got) begin
        checks++;
        errors++;
        $display("FAIL scan_timeout: got no scan_done expected one within 2000 cycles");
      end
    end
  endtask

  function automatic bit has_ev(input logic [5:0] k, input logic p);
    for (int i = 0; i < evq.size(); i++) begin
      if (evq[i].key == k && evq[i].press == p) return 1'b1;
    end
    return 1'b0;
  endfunction

  initial begin
    logic [55:0] exp_mask;
    int first_done;
    int second_done;
    int n_done;
    int bad;
    bit found;

    tbl[0] = '{k: 2, j: 5, key: 18};
    tbl[1] = '{k: 0, j: 1, key: 0};
    tbl[2] = '{k: 7, j: 6, key: 55};
    tbl[3] = '{k: 7, j: 0, key: 49};
    tbl[4] = '{k: 0, j: 7, key: 6};
    tbl[5] = '{k: 3, j: 0, key: 21};

    rst_n    = 1'b0;
    enable   = 1'b0;
    ev_ready = 1'b1;
    pairs    = '0;

    // Reset with scanning disabled.
    tick(3);
    chk("rst_tris", 64'(tris), 64'hFF);
    chk("rst_drive", 64'(drive), 64'h0);
    chk("rst_keys", 64'(keys), 64'h0);
    chk("rst_valid", 64'(ev_valid), 64'h0);
    chk("rst_key", 64'(ev_key), 64'h0);
    chk("rst_press", 64'(ev_press), 64'h0);
    chk("rst_done", 64'(scan_done), 64'h0);

    // Enable: line timing and scan period.
    rst_n  = 1'b1;
    enable = 1'b1;
    first_done  = 0;
    second_done = 0;
    n_done      = 0;
    for (int n = 1; n <= 3456; n++) begin
      @(negedge clk);
      if (n == 1)   chk("tris_first", 64'(tris), 64'hFE);
      if (n == 5)   chk("drive_low", 64'(drive), 64'h0);
      if (n == 216) chk("tris_sample", 64'(tris), 64'hFE);
      if (n == 217) chk("tris_line1", 64'(tris), 64'hFD);
      if (scan_done) begin
        n_done++;
        if (n_done == 1) first_done = n;
        if (n_done == 2) second_done = n;
      end
    end
    chk("done_first", 64'(first_done), 64'd1728);
    chk("done_second", 64'(second_done), 64'd3456);
    chk("done_count", 64'(n_done), 64'd2);

    // Table: press every listed site together for four scans, then release.
    evq.delete();
    exp_mask = '0;
    foreach (tbl[i]) begin
      pairs[8*tbl[i].k + tbl[i].j] = 1'b1;
      exp_mask[tbl[i].key] = 1'b1;
    end
    wait_scans(3);
    tick(1);
    chk("tbl_3scans_keys", 64'(keys), 64'h0);
    wait_scans(1);
    tick(4);
    foreach (tbl[i]) begin
      chk($sformatf("tbl_key%0d_pressed", tbl[i].key), 64'(keys[tbl[i].key]), 64'h1);
      chk($sformatf("tbl_key%0d_press_ev", tbl[i].key), 64'(has_ev(6'(tbl[i].key), 1'b1)), 64'h1);
    end
    chk("tbl_keys_mask", 64'(keys), 64'(exp_mask));
    chk("tbl_press_ev_count", 64'(evq.size()), 64'd6);

    evq.delete();
    pairs = '0;
    wait_scans(4);
    tick(4);
    foreach (tbl[i]) begin
      chk($sformatf("tbl_key%0d_release_ev", tbl[i].key), 64'(has_ev(6'(tbl[i].key), 1'b0)), 64'h1);
    end
    chk("tbl_release_keys", 64'(keys), 64'h0);
    chk("tbl_release_ev_count", 64'(evq.size()), 64'd6);

    // Glitch: two three-scan presses split by one released scan never qualify.
    evq.delete();
    pairs[8*2+5] = 1'b1;
    wait_scans(3);
    pairs = '0;
    wait_scans(1);
    pairs[8*2+5] = 1'b1;
    wait_scans(3);
    pairs = '0;
    wait_scans(1);
    tick(2);
    chk("glitch_keys", 64'(keys), 64'h0);
    chk("glitch_no_ev", 64'(evq.size()), 64'd0);

    // Backpressure: keys 3 and 40 qualify while the consumer stalls.
    ev_ready = 1'b0;
    evq.delete();
    pairs[8*0+4] = 1'b1;
    pairs[8*5+6] = 1'b1;
    wait_scans(4);
    tick(1);
    chk("bp_keys", 64'(keys), 64'h0000_0100_0000_0008);
    chk("bp_valid", 64'(ev_valid), 64'h1);
    chk("bp_key3", 64'(ev_key), 64'd3);
    chk("bp_press3", 64'(ev_press), 64'h1);
    bad = 0;
    repeat (100) begin
      @(negedge clk);
      if (!ev_valid || ev_key != 6'd3 || !ev_press) bad++;
    end
    chk("bp_hold_cycles_bad", 64'(bad), 64'd0);
    ev_ready = 1'b1;
    @(negedge clk);
    chk("bp_next_valid", 64'(ev_valid), 64'h1);
    chk("bp_next_key40", 64'(ev_key), 64'd40);
    chk("bp_next_press", 64'(ev_press), 64'h1);
    @(negedge clk);
    chk("bp_drained", 64'(ev_valid), 64'h0);
    chk("bp_ev_count", 64'(evq.size()), 64'd2);
    chk("bp_ev3", 64'(has_ev(6'd3, 1'b1)), 64'h1);
    chk("bp_ev40", 64'(has_ev(6'd40, 1'b1)), 64'h1);

    // Coalesce: key 3 release blocks the register while key 10 presses and releases.
    ev_ready = 1'b0;
    wait_scans(1);
    evq.delete();
    pairs[8*0+4] = 1'b0;
    pairs[8*1+4] = 1'b1;
    wait_scans(4);
    tick(1);
    chk("co_block_valid", 64'(ev_valid), 64'h1);
    chk("co_block_key", 64'(ev_key), 64'd3);
    chk("co_block_press", 64'(ev_press), 64'h0);
    chk("co_key10_down", 64'(keys[10]), 64'h1);
    pairs[8*1+4] = 1'b0;
    wait_scans(4);
    tick(1);
    chk("co_key10_up", 64'(keys[10]), 64'h0);
    chk("co_still_key3", 64'(ev_key), 64'd3);
    ev_ready = 1'b1;
    tick(4);
    chk("co_ev_count", 64'(evq.size()), 64'd2);
    chk("co_ev3_release", 64'(has_ev(6'd3, 1'b0)), 64'h1);
    chk("co_ev10_release", 64'(has_ev(6'd10, 1'b0)), 64'h1);
    chk("co_no_ev10_press", 64'(has_ev(6'd10, 1'b1)), 64'h0);
    chk("co_drained", 64'(ev_valid), 64'h0);

    // Disable during the drive of line 4, then restart.
    wait_scans(1);
    found = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      if (tris == 8'hEF) begin
        found = 1'b1;
        break;
      end
    end
    chk("dis_reach_line4", 64'(found), 64'h1);
    tick(10);
    enable = 1'b0;
    @(negedge clk);
    chk("dis_tris", 64'(tris), 64'hFF);
    chk("dis_keys_kept", 64'(keys), 64'h0000_0100_0000_0000);
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (tris != 8'hFF || scan_done) bad++;
    end
    chk("dis_idle_cycles_bad", 64'(bad), 64'd0);
    enable = 1'b1;
    @(negedge clk);
    chk("reen_tris_line0", 64'(tris), 64'hFE);

    // Reset mid-drive.
    tick(50);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mrst_tris", 64'(tris), 64'hFF);
    chk("mrst_keys", 64'(keys), 64'h0);
    chk("mrst_valid", 64'(ev_valid), 64'h0);
    chk("mrst_key", 64'(ev_key), 64'h0);
    chk("mrst_press", 64'(ev_press), 64'h0);
    chk("mrst_done", 64'(scan_done), 64'h0);
    rst_n = 1'b1;
    evq.delete();
    bad = 0;
    repeat (300) begin
      @(negedge clk);
      if (ev_valid) bad++;
    end
    chk("mrst_no_valid", 64'(bad), 64'd0);
    chk("mrst_no_ev", 64'(evq.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
